// File: rtl/rbe_accum_ctrl_pkg.sv
// Shared types for the accumulator-bank sequencer.
//
// Contents:
//   acc_op_e      command opcode carried on cmd_op_i (CLEAR / DRAIN)
//   ctrl_state_e  sequencer FSM state
package rbe_accum_ctrl_pkg;

    typedef enum logic {
        ACC_OP_CLEAR = 1'b0,
        ACC_OP_DRAIN = 1'b1
    } acc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAIN = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/rbe_accum_drain_seq.sv
// Drain sequencer: walks the accumulator bank one wide beat at a time and
// presents each beat on a valid/ready output.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   en_i           high for the whole DRAIN state; low clears all progress
//   ready_i        downstream consumed the current beat
//   issue_o        wide read issued to the SCM this cycle
//   raddr_o        SCM read address of the issued beat (beat * WIDTH_FACTOR)
//   valid_o        a beat is held on the SCM wide read port
//   last_o         the held beat is the final one
//   done_o         the final beat is being handed over this cycle
module rbe_accum_drain_seq #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned NUM_WORDS    = 2**ADDR_WIDTH,
    parameter int unsigned WIDTH_FACTOR = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  ready_i,
    output logic                  issue_o,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    output logic                  valid_o,
    output logic                  last_o,
    output logic                  done_o
);

    localparam int unsigned NUM_BEATS = NUM_WORDS / WIDTH_FACTOR;
    localparam int unsigned BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [BW:0]   BEATS_C = (BW+1)'(NUM_BEATS);
    localparam logic [BW-1:0] LAST_C  = BW'(NUM_BEATS - 1);

    // issue_cnt_q counts beats already requested (one extra bit so it can
    // reach NUM_BEATS and stop); out_beat_q tags the beat currently shown.
    logic [BW:0]   issue_cnt_q;
    logic [BW-1:0] out_beat_q;
    logic          valid_q;
    logic          fire;

    assign fire    = valid_q & ready_i;
    // The SCM read port doubles as the output register, so a new read may
    // only be issued when the shown beat is gone or leaving this cycle.
    assign issue_o = en_i & (issue_cnt_q < BEATS_C) & (~valid_q | ready_i);
    assign raddr_o = issue_o ? ADDR_WIDTH'(issue_cnt_q[BW-1:0]) * ADDR_WIDTH'(WIDTH_FACTOR)
                             : '0;
    assign valid_o = valid_q;
    assign last_o  = valid_q & (out_beat_q == LAST_C);
    assign done_o  = fire & (out_beat_q == LAST_C);

    // Beat bookkeeping; everything restarts whenever the drain is not active.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_cnt_q <= '0;
            out_beat_q  <= '0;
            valid_q     <= 1'b0;
        end else if (!en_i) begin
            issue_cnt_q <= '0;
            out_beat_q  <= '0;
            valid_q     <= 1'b0;
        end else if (issue_o) begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
            out_beat_q  <= issue_cnt_q[BW-1:0];
            valid_q     <= 1'b1;
        end else if (fire) begin
            valid_q     <= 1'b0;
        end
    end

endmodule

// File: rtl/rbe_accumulators_ctrl.sv
// Sequencer for the latch-based accumulator bank. Arbitrates between
// read-modify-write accumulate requests, CLEAR and DRAIN commands, and
// drives every control pin of the SCM.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cmd_valid_i/ready_o, cmd_op_i command handshake (0 = CLEAR, 1 = DRAIN)
//   acc_valid_i/ready_o           accumulate handshake
//   acc_addr_i, acc_data_i        target accumulator and signed addend
//   drain_valid_o/ready_i         drain beat handshake
//   drain_data_o, drain_last_o    wide beat (word 0 in LSBs), final-beat flag
//   busy_o                        FSM not idle or accumulate still in flight
//   scm_*                         SCM controls, addresses and data
module rbe_accumulators_ctrl
    import rbe_accum_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_WORDS    = 2**ADDR_WIDTH,
    parameter int unsigned WIDTH_FACTOR = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 cmd_valid_i,
    output logic                                 cmd_ready_o,
    input  logic                                 cmd_op_i,
    input  logic                                 acc_valid_i,
    output logic                                 acc_ready_o,
    input  logic [ADDR_WIDTH-1:0]                acc_addr_i,
    input  logic [DATA_WIDTH-1:0]                acc_data_i,
    output logic                                 drain_valid_o,
    input  logic                                 drain_ready_i,
    output logic [WIDTH_FACTOR*DATA_WIDTH-1:0]   drain_data_o,
    output logic                                 drain_last_o,
    output logic                                 busy_o,
    output logic                                 scm_clear_o,
    output logic                                 scm_re_o,
    output logic                                 scm_we_o,
    output logic                                 scm_wide_enable_o,
    output logic [ADDR_WIDTH-1:0]                scm_raddr_o,
    output logic [ADDR_WIDTH-1:0]                scm_waddr_o,
    output logic [DATA_WIDTH-1:0]                scm_wdata_o,
    input  logic [DATA_WIDTH-1:0]                scm_rdata_i,
    input  logic [WIDTH_FACTOR*DATA_WIDTH-1:0]   scm_rdata_wide_i
);

    ctrl_state_e state_q, state_d;

    // run_q keeps both handshakes closed while reset is held and for the
    // first cycle after release, so every output reads 0 during reset.
    logic run_q;

    // Stage W holds the accumulate whose read was issued last cycle; the
    // previous-write slot remembers the address written one cycle ago,
    // because the latch bank only exposes a write one cycle after we.
    logic                  w_valid_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic                  pw_valid_q;
    logic [ADDR_WIDTH-1:0] pw_addr_q;

    logic acc_hazard;
    logic acc_fire;
    logic cmd_fire;

    logic                  drain_en;
    logic                  drain_issue;
    logic                  drain_done;
    logic [ADDR_WIDTH-1:0] drain_raddr;

    assign acc_hazard = (w_valid_q  && (acc_addr_i == w_addr_q)) ||
                        (pw_valid_q && (acc_addr_i == pw_addr_q));

    // Commands take priority: a pending command blocks new accumulates so
    // the pipeline drains and the command is accepted within two cycles.
    assign acc_ready_o = run_q && (state_q == ST_IDLE) && !cmd_valid_i && !acc_hazard;
    assign cmd_ready_o = run_q && (state_q == ST_IDLE) && !w_valid_q && !pw_valid_q;
    assign acc_fire    = acc_valid_i && acc_ready_o;
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;

    assign busy_o       = (state_q != ST_IDLE) || w_valid_q || pw_valid_q;
    assign drain_data_o = scm_rdata_wide_i;
    assign drain_en     = (state_q == ST_DRAIN);

    rbe_accum_drain_seq #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .NUM_WORDS    (NUM_WORDS),
        .WIDTH_FACTOR (WIDTH_FACTOR)
    ) i_drain_seq (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (drain_en),
        .ready_i (drain_ready_i),
        .issue_o (drain_issue),
        .raddr_o (drain_raddr),
        .valid_o (drain_valid_o),
        .last_o  (drain_last_o),
        .done_o  (drain_done)
    );

    // State register plus the out-of-reset qualifier.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Accumulate pipeline: read in the handshake cycle, write back one
    // cycle later, then remember that address for one more cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_valid_q  <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            pw_valid_q <= 1'b0;
            pw_addr_q  <= '0;
        end else begin
            w_valid_q  <= acc_fire;
            if (acc_fire) begin
                w_addr_q <= acc_addr_i;
                w_data_q <= acc_data_i;
            end
            pw_valid_q <= w_valid_q;
            pw_addr_q  <= w_addr_q;
        end
    end

    // Next state and SCM controls. The write-back of stage W is the default
    // since commands are only accepted once stage W is empty.
    always_comb begin
        state_d           = state_q;
        scm_clear_o       = 1'b0;
        scm_re_o          = 1'b0;
        scm_raddr_o       = '0;
        scm_wide_enable_o = 1'b0;
        scm_we_o          = w_valid_q;
        scm_waddr_o       = w_valid_q ? w_addr_q : '0;
        scm_wdata_o       = w_valid_q ? (scm_rdata_i + w_data_q) : '0;

        case (state_q)
            ST_IDLE: begin
                if (acc_fire) begin
                    scm_re_o    = 1'b1;
                    scm_raddr_o = acc_addr_i;
                end
                if (cmd_fire) begin
                    state_d = (acc_op_e'(cmd_op_i) == ACC_OP_DRAIN) ? ST_DRAIN : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                scm_clear_o = 1'b1;
                scm_we_o    = 1'b0;
                scm_waddr_o = '0;
                scm_wdata_o = '0;
                state_d     = ST_IDLE;
            end
            ST_DRAIN: begin
                scm_wide_enable_o = 1'b1;
                scm_re_o          = drain_issue;
                scm_raddr_o       = drain_raddr;
                if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rbe_accumulators_ctrl.sv
// Directed testbench for rbe_accumulators_ctrl with a behavioural model of
// the latch-based accumulator bank (writes become readable one cycle after
// the write-enable cycle; read ports hold their value while re is low).
module tb_rbe_accumulators_ctrl;

    logic         clk_i;
    logic         rst_ni;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic         cmd_op_i;
    logic         acc_valid_i;
    logic         acc_ready_o;
    logic [4:0]   acc_addr_i;
    logic [31:0]  acc_data_i;
    logic         drain_valid_o;
    logic         drain_ready_i;
    logic [127:0] drain_data_o;
    logic         drain_last_o;
    logic         busy_o;
    logic         scm_clear_o;
    logic         scm_re_o;
    logic         scm_we_o;
    logic         scm_wide_enable_o;
    logic [4:0]   scm_raddr_o;
    logic [4:0]   scm_waddr_o;
    logic [31:0]  scm_wdata_o;
    logic [31:0]  scm_rdata;
    logic [127:0] scm_rdata_wide;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] got_beat [8];

    rbe_accumulators_ctrl #(
        .ADDR_WIDTH   (5),
        .DATA_WIDTH   (32),
        .NUM_WORDS    (32),
        .WIDTH_FACTOR (4)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_op_i          (cmd_op_i),
        .acc_valid_i       (acc_valid_i),
        .acc_ready_o       (acc_ready_o),
        .acc_addr_i        (acc_addr_i),
        .acc_data_i        (acc_data_i),
        .drain_valid_o     (drain_valid_o),
        .drain_ready_i     (drain_ready_i),
        .drain_data_o      (drain_data_o),
        .drain_last_o      (drain_last_o),
        .busy_o            (busy_o),
        .scm_clear_o       (scm_clear_o),
        .scm_re_o          (scm_re_o),
        .scm_we_o          (scm_we_o),
        .scm_wide_enable_o (scm_wide_enable_o),
        .scm_raddr_o       (scm_raddr_o),
        .scm_waddr_o       (scm_waddr_o),
        .scm_wdata_o       (scm_wdata_o),
        .scm_rdata_i       (scm_rdata),
        .scm_rdata_wide_i  (scm_rdata_wide)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Accumulator bank model: a write is parked for one cycle before it
    // lands in the array, mimicking the latch bank's write timing.
    logic [31:0] mem [32];
    logic        pend_we;
    logic [4:0]  pend_addr;
    logic [31:0] pend_data;

    initial begin
        pend_we        = 1'b0;
        pend_addr      = '0;
        pend_data      = '0;
        scm_rdata      = '0;
        scm_rdata_wide = '0;
    end

    always @(posedge clk_i) begin
        if (scm_clear_o) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            pend_we <= 1'b0;
        end else begin
            if (pend_we) mem[pend_addr] <= pend_data;
            pend_we   <= scm_we_o;
            pend_addr <= scm_waddr_o;
            pend_data <= scm_wdata_o;
        end
        if (scm_re_o) begin
            scm_rdata <= mem[scm_raddr_o];
            if (scm_wide_enable_o) begin
                for (int j = 0; j < 4; j++) scm_rdata_wide[32*j +: 32] <= mem[scm_raddr_o + j];
            end
        end
    end

    // Expected beat k after accumulating addr+1 into every address.
    function automatic logic [127:0] seq_beat(input int k);
        logic [127:0] b;
        for (int j = 0; j < 4; j++) b[32*j +: 32] = 32'(4*k + j + 1);
        return b;
    endfunction

    // Drive one accumulate; returns the number of cycles it waited for
    // ready (-1 if it never came). Handshake completes at the next posedge.
    task automatic do_acc(input logic [4:0] a, input logic [31:0] d, output int waited);
        @(negedge clk_i);
        acc_valid_i = 1'b1;
        acc_addr_i  = a;
        acc_data_i  = d;
        waited      = 0;
        #1;
        while (!acc_ready_o && waited < 20) begin
            @(negedge clk_i);
            #1;
            waited++;
        end
        if (!acc_ready_o) waited = -1;
    endtask

    task automatic acc_idle();
        @(negedge clk_i);
        acc_valid_i = 1'b0;
    endtask

    // Issue a command and release it; returns at the negedge of the first
    // cycle in the commanded state.
    task automatic do_cmd(input logic op, output int waited);
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        waited      = 0;
        #1;
        while (!cmd_ready_o && waited < 40) begin
            @(negedge clk_i);
            #1;
            waited++;
        end
        if (!cmd_ready_o) waited = -1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    // Full-rate drain started right after do_cmd(DRAIN); captures beats.
    task automatic run_drain(output int nbeats, output int span, output int re_cnt,
                             output int last_idx);
        int first;
        first    = -1;
        nbeats   = 0;
        span     = 0;
        re_cnt   = 0;
        last_idx = -1;
        drain_ready_i = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (scm_re_o) re_cnt++;
            if (drain_valid_o) begin
                if (first < 0) first = cyc;
                if (nbeats < 8) got_beat[nbeats] = drain_data_o;
                if (drain_last_o && last_idx < 0) last_idx = nbeats;
                nbeats++;
                if (drain_last_o) begin
                    span = cyc - first + 1;
                    break;
                end
            end
            @(negedge clk_i);
        end
        @(negedge clk_i);
        drain_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni        = 1'b0;
        cmd_valid_i   = 1'b0;
        cmd_op_i      = 1'b0;
        acc_valid_i   = 1'b0;
        acc_addr_i    = '0;
        acc_data_i    = '0;
        drain_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        n_checks++;
        if ({cmd_ready_o, acc_ready_o, drain_valid_o, drain_last_o, busy_o, scm_clear_o,
             scm_re_o, scm_we_o, scm_wide_enable_o, scm_raddr_o, scm_waddr_o, scm_wdata_o} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got re=%b we=%b busy=%b accr=%b cmdr=%b expected all 0",
                     scm_re_o, scm_we_o, busy_o, acc_ready_o, cmd_ready_o);
        end
        n_checks++;
        if (drain_data_o !== scm_rdata_wide) begin
            n_fail++;
            $display("[TB] FAIL reset_drain_data: got %h expected %h", drain_data_o, scm_rdata_wide);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_clear_drain_zero();
        int w, nb, span, rc, li;
        do_cmd(1'b0, w);
        #1;
        n_checks++;
        if (scm_clear_o !== 1'b1 || scm_re_o !== 1'b0 || scm_we_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clear_cycle: got clear=%b re=%b we=%b busy=%b expected 1 0 0 1",
                     scm_clear_o, scm_re_o, scm_we_o, busy_o);
        end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (scm_clear_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_one_cycle: got clear=%b busy=%b expected 0 0", scm_clear_o, busy_o);
        end
        do_cmd(1'b1, w);
        run_drain(nb, span, rc, li);
        n_checks++;
        if (nb !== 8 || span !== 8 || li !== 7 || rc !== 8) begin
            n_fail++;
            $display("[TB] FAIL zero_drain_shape: got beats=%0d span=%0d last=%0d re=%0d expected 8 8 7 8",
                     nb, span, li, rc);
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_beat[k] !== 128'd0) begin
                n_fail++;
                $display("[TB] FAIL zero_beat%0d: got %h expected 0", k, got_beat[k]);
            end
        end
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || drain_valid_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL drain_end: got busy=%b valid=%b expected 0 0", busy_o, drain_valid_o);
        end
    endtask

    task automatic test_same_addr();
        int w0, w1, w2, w, nb, span, rc, li;
        do_cmd(1'b0, w);
        do_acc(5'd3, 32'd5, w0);
        do_acc(5'd3, 32'hFFFF_FFFE, w1);
        do_acc(5'd3, 32'd10, w2);
        acc_idle();
        n_checks++;
        if (w0 !== 0 || w1 !== 2 || w2 !== 2) begin
            n_fail++;
            $display("[TB] FAIL same_addr_gap: got waits %0d %0d %0d expected 0 2 2", w0, w1, w2);
        end
        do_cmd(1'b1, w);
        run_drain(nb, span, rc, li);
        n_checks++;
        if (nb !== 8 || got_beat[0] !== {32'd13, 96'd0}) begin
            n_fail++;
            $display("[TB] FAIL same_addr_sum: got beats=%0d beat0=%h expected 8 word3=13", nb, got_beat[0]);
        end
        n_checks++;
        if (got_beat[1] !== 128'd0 || got_beat[7] !== 128'd0) begin
            n_fail++;
            $display("[TB] FAIL same_addr_others: got %h %h expected 0", got_beat[1], got_beat[7]);
        end
    endtask

    task automatic test_back_to_back();
        int w, waits, nb, span, rc, li;
        do_cmd(1'b0, w);
        waits = 0;
        for (int a = 0; a < 32; a++) begin
            do_acc(5'(a), 32'(a + 1), w);
            waits += (w < 0) ? 100 : w;
        end
        acc_idle();
        n_checks++;
        if (waits !== 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_ready: got %0d stall cycles expected 0", waits);
        end
        do_cmd(1'b1, w);
        run_drain(nb, span, rc, li);
        n_checks++;
        if (nb !== 8 || span !== 8 || li !== 7) begin
            n_fail++;
            $display("[TB] FAIL b2b_shape: got beats=%0d span=%0d last=%0d expected 8 8 7", nb, span, li);
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_beat[k] !== seq_beat(k)) begin
                n_fail++;
                $display("[TB] FAIL b2b_beat%0d: got %h expected %h", k, got_beat[k], seq_beat(k));
            end
        end
    endtask

    // Drain the bank left by test_back_to_back with ready toggling 1,0,0,1.
    task automatic test_drain_stall();
        int w, n, re_cnt;
        logic stalled;
        logic [127:0] held;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        n       = 0;
        re_cnt  = 0;
        stalled = 1'b0;
        held    = '0;
        do_cmd(1'b1, w);
        for (int cyc = 0; cyc < 80 && n < 8; cyc++) begin
            drain_ready_i = pat[cyc % 4];
            #1;
            if (scm_re_o) re_cnt++;
            if (stalled) begin
                n_checks++;
                if (drain_valid_o !== 1'b1 || drain_data_o !== held) begin
                    n_fail++;
                    $display("[TB] FAIL stall_hold: got valid=%b data=%h expected 1 %h",
                             drain_valid_o, drain_data_o, held);
                end
            end
            if (drain_valid_o) begin
                if (drain_ready_i) begin
                    got_beat[n] = drain_data_o;
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = drain_data_o;
                end
            end
            @(negedge clk_i);
        end
        drain_ready_i = 1'b0;
        #1;
        n_checks++;
        if (n !== 8 || re_cnt !== 8 || busy_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stall_counts: got beats=%0d re=%0d busy=%b expected 8 8 0", n, re_cnt, busy_o);
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_beat[k] !== seq_beat(k)) begin
                n_fail++;
                $display("[TB] FAIL stall_beat%0d: got %h expected %h", k, got_beat[k], seq_beat(k));
            end
        end
    endtask

    task automatic test_wrap();
        int w, w1, nb, span, rc, li;
        do_cmd(1'b0, w);
        do_acc(5'd7, 32'h7FFF_FFFF, w);
        do_acc(5'd7, 32'd1, w1);
        acc_idle();
        do_cmd(1'b1, w);
        run_drain(nb, span, rc, li);
        n_checks++;
        if (w1 !== 2 || got_beat[1] !== {32'h8000_0000, 96'd0}) begin
            n_fail++;
            $display("[TB] FAIL wrap_word7: got wait=%0d beat1=%h expected 2 word3=80000000", w1, got_beat[1]);
        end
    endtask

    task automatic test_cmd_priority_and_reset();
        int w;
        do_cmd(1'b0, w);
        do_acc(5'd1, 32'd1, w);
        do_acc(5'd2, 32'd2, w);
        @(negedge clk_i);
        acc_addr_i  = 5'd3;
        acc_data_i  = 32'd3;
        cmd_valid_i = 1'b1;
        cmd_op_i    = 1'b1;
        #1;
        n_checks++;
        if (acc_ready_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL cmd_blocks_acc: got acc_ready=%b cmd_ready=%b expected 0 0", acc_ready_o, cmd_ready_o);
        end
        w = 0;
        while (!cmd_ready_o && w < 10) begin
            @(negedge clk_i);
            #1;
            w++;
        end
        n_checks++;
        if (w !== 2 || cmd_ready_o !== 1'b1 || acc_ready_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL cmd_latency: got %0d cycles cmd_ready=%b acc_ready=%b expected 2 1 0",
                     w, cmd_ready_o, acc_ready_o);
        end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        acc_valid_i = 1'b0;
        @(negedge clk_i);
        #1;
        n_checks++;
        if (drain_valid_o !== 1'b1 || scm_wide_enable_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_drain: got valid=%b wide=%b expected 1 1", drain_valid_o, scm_wide_enable_o);
        end
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready_o, acc_ready_o, drain_valid_o, drain_last_o, busy_o, scm_clear_o,
             scm_re_o, scm_we_o, scm_wide_enable_o, scm_raddr_o, scm_waddr_o, scm_wdata_o} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_drain: got valid=%b busy=%b wide=%b re=%b expected all 0",
                     drain_valid_o, busy_o, scm_wide_enable_o, scm_re_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || drain_valid_o !== 1'b0 || scm_wide_enable_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got busy=%b valid=%b wide=%b expected 0 0 0",
                     busy_o, drain_valid_o, scm_wide_enable_o);
        end
        repeat (2) @(negedge clk_i);
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready_after_reset: got cmd_ready=%b expected 1", cmd_ready_o);
        end
    endtask

    initial begin
        $display("[TB] starting rbe_accumulators_ctrl directed tests");
        test_reset();
        test_clear_drain_zero();
        test_same_addr();
        test_back_to_back();
        test_drain_stall();
        test_wrap();
        test_cmd_priority_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
